// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the MEM stage and a word-only data memory.
// Latency: load/word store 2 cycles, sub-word store 3 cycles (read-modify-write), error 1 cycle.
// Backpressure: req_ready is high only in IDLE; the MEM stage stalls while an access is in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (we, size, signed, addr, wdata)
//   resp_valid/resp_rdata/resp_err one-cycle completion pulse with extended load data / error flag
//   mem_addr/mem_we/mem_wd/mem_rd word-aligned memory port, mem_rd combinational from mem_addr
module lsu_mem_ctrl #(
   parameter int DATA_MEM_SIZE = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_DONE} state_t;

   state_t      r_state;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_old;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;

   logic        w_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merge;
   logic        w_write;
   logic        w_mem_busy;

   // Request checks, evaluated on the live request at acceptance.
   assign w_err = (req_size == 2'b11)
                | ((req_size == 2'b01) & req_addr[0])
                | ((req_size == 2'b10) & (|req_addr[1:0]))
                | ({2'b00, req_addr[31:2]} >= 32'(DATA_MEM_SIZE));

   // Lane extraction for loads and lane replacement for sub-word stores (little-endian).
   always_comb begin
      w_byte = mem_rd[7:0];
      case (r_addr[1:0])
         2'd1:    w_byte = mem_rd[15:8];
         2'd2:    w_byte = mem_rd[23:16];
         2'd3:    w_byte = mem_rd[31:24];
         default: w_byte = mem_rd[7:0];
      endcase
      w_half = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];

      case (r_size)
         2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
         default: w_load = mem_rd;
      endcase

      w_merge = r_old;
      if (r_size == 2'b00) begin
         case (r_addr[1:0])
            2'd1:    w_merge[15:8]  = r_wdata[7:0];
            2'd2:    w_merge[23:16] = r_wdata[7:0];
            2'd3:    w_merge[31:24] = r_wdata[7:0];
            default: w_merge[7:0]   = r_wdata[7:0];
         endcase
      end else if (r_addr[1]) begin
         w_merge[31:16] = r_wdata[15:0];
      end else begin
         w_merge[15:0] = r_wdata[15:0];
      end
   end

   // Gating with ~rst guarantees no write lands on a reset edge, whatever state we were in.
   assign w_write    = ~rst & (((r_state == S_ACCESS) & r_we & (r_size == 2'b10))
                               | (r_state == S_MERGE));
   assign w_mem_busy = ~rst & ((r_state == S_ACCESS) | (r_state == S_MERGE));

   assign mem_we   = w_write;
   assign mem_wd   = w_write ? ((r_state == S_MERGE) ? w_merge : r_wdata) : 32'h0;
   assign mem_addr = w_mem_busy ? {r_addr[31:2], 2'b00} : 32'h0;

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
         r_we         <= 1'b0;
         r_size       <= 2'b00;
         r_signed     <= 1'b0;
         r_addr       <= 32'h0;
         r_wdata      <= 32'h0;
         r_old        <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_size      <= req_size;
                  r_signed    <= req_signed;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (w_err) begin
                     // Errors never touch memory; respond straight away.
                     r_state      <= S_DONE;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= 32'h0;
                     r_resp_err   <= 1'b1;
                  end else begin
                     r_state <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (!r_we) begin
                  r_state      <= S_DONE;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= w_load;
                  r_resp_err   <= 1'b0;
               end else if (r_size == 2'b10) begin
                  r_state      <= S_DONE;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= 32'h0;
                  r_resp_err   <= 1'b0;
               end else begin
                  // Sub-word store: this cycle is the read half of read-modify-write.
                  r_old   <= mem_rd;
                  r_state <= S_MERGE;
               end
            end
            S_MERGE: begin
               r_state      <= S_DONE;
               r_resp_valid <= 1'b1;
               r_resp_rdata <= 32'h0;
               r_resp_err   <= 1'b0;
            end
            S_DONE: begin
               r_state      <= S_IDLE;
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
            end
            default: begin
               r_state      <= S_IDLE;
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: drives lsu_mem_ctrl against a simple word memory and a reference model.
// Latency: n/a (testbench).
// Backpressure: requests are presented only when the DUT is idle, except in the back-to-back scenario.
module tb_lsu_mem_ctrl;

   localparam int MSZ = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   int checks   = 0;
   int failures = 0;

   // Memory attached to the DUT, and the reference model's own copy.
   logic [31:0] mem     [MSZ];
   logic [31:0] ref_mem [MSZ];
   int          wr_count = 0;
   logic        pl_en = 1'b0;
   int          pl_idx = 0;
   logic [31:0] pl_val = 32'h0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.DATA_MEM_SIZE(MSZ)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always_comb begin
      mem_rd = 32'h0;
      if (mem_addr[31:2] < MSZ) mem_rd = mem[mem_addr[7:2]];
   end

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      if (mem_we) begin
         mem[mem_addr[7:2]] <= mem_wd;
         wr_count <= wr_count + 1;
      end
   end

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_val = val;
      ref_mem[idx] = val;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // Reference model: computes the expected outcome from the access rules directly.
   task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output int nwr);
      int unsigned idx, sh;
      logic [31:0] w, v;
      idx = a / 4;
      er  = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || (idx >= MSZ);
      rd = 0; nwr = 0;
      if (er) begin
         lat = 1;
      end else if (!we) begin
         lat = 2;
         w = ref_mem[idx];
         if (sz == 0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (sg && v >= 128) v = v - 256;
         end else if (sz == 1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (sg && v >= 32768) v = v - 65536;
         end else begin
            v = w;
         end
         rd = v;
      end else begin
         nwr = 1;
         w = ref_mem[idx];
         if (sz == 2) begin
            lat = 2;
            ref_mem[idx] = wd;
         end else if (sz == 0) begin
            lat = 3;
            sh = 8 * (a % 4);
            ref_mem[idx] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
         end else begin
            lat = 3;
            sh = 16 * ((a / 2) % 2);
            ref_mem[idx] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
         end
      end
   endtask

   // Issues one request from IDLE and observes latency, response and number of memory writes.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat, output int nwr);
      int w0;
      @(negedge clk);
      w0 = wr_count;
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      // Scramble the fields: the DUT must have registered them at acceptance.
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      lat = 0; rd = 32'h0; er = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (resp_valid) begin
            lat = i; rd = resp_rdata; er = resp_err;
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      nwr = wr_count - w0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp got=%h/%b exp=0/0", resp_rdata, resp_err); end
      checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin failures++; $display("FAIL reset_mem got=%b/%h/%h exp=0/0/0", mem_we, mem_addr, mem_wd); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_word_store_load();
      logic [31:0] rd; logic er; int lat, nwr;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, nwr);
      ref_mem[4] = 32'hDEADBEEF;
      checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
      checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
      checks++; if (nwr !== 1 || rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL sw_resp got=%0d/%h/%b exp=1/0/0", nwr, rd, er); end
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, nwr);
      checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL lw_data got=%h/%b exp=deadbeef/0", rd, er); end
      checks++; if (lat !== 2 || nwr !== 0) begin failures++; $display("FAIL lw_timing got=%0d/%0d exp=2/0", lat, nwr); end
   endtask

   task automatic test_byte_rmw();
      logic [31:0] rd; logic er; int lat, nwr;
      preload(4, 32'h11223344);
      // Watch the read cycle directly.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h12; req_wdata = 32'h555555AA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h10) begin failures++; $display("FAIL rmw_read got=%b/%h exp=0/00000010", mem_we, mem_addr); end
      @(posedge clk);
      #1;
      checks++; if (mem_we !== 1'b1 || mem_wd !== 32'h11AA3344) begin failures++; $display("FAIL rmw_write got=%b/%h exp=1/11aa3344", mem_we, mem_wd); end
      @(posedge clk);
      #1;
      checks++; if (resp_valid !== 1'b1 || mem[4] !== 32'h11AA3344) begin failures++; $display("FAIL rmw_done got=%b/%h exp=1/11aa3344", resp_valid, mem[4]); end
      @(posedge clk);
      ref_mem[4] = 32'h11AA3344;
      do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC, rd, er, lat, nwr);
      checks++; if (lat !== 3 || nwr !== 1 || mem[4] !== 32'h11AACC44) begin failures++; $display("FAIL sb_lat got=%0d/%0d/%h exp=3/1/11aacc44", lat, nwr, mem[4]); end
      ref_mem[4] = 32'h11AACC44;
   endtask

   task automatic test_subword_loads();
      logic [31:0] rd; logic er; int lat, nwr;
      preload(4, 32'h80FF7F01);
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat, nwr);
      checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb got=%h exp=ffffff80", rd); end
      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat, nwr);
      checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu got=%h exp=00000080", rd); end
      do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat, nwr);
      checks++; if (rd !== 32'hFFFF80FF) begin failures++; $display("FAIL lh got=%h exp=ffff80ff", rd); end
      do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat, nwr);
      checks++; if (rd !== 32'h00007F01 || lat !== 2) begin failures++; $display("FAIL lhu got=%h/%0d exp=00007f01/2", rd, lat); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat, nwr;
      logic        t_we [4];
      logic [1:0]  t_sz [4];
      logic [31:0] t_a  [4];
      t_we = '{1'b0, 1'b1, 1'b0, 1'b0};
      t_sz = '{2'b01, 2'b10, 2'b11, 2'b10};
      t_a  = '{32'h11, 32'h12, 32'h10, 32'(4 * MSZ)};
      for (int i = 0; i < 4; i++) begin
         do_req(t_we[i], t_sz[i], 1'b1, t_a[i], 32'hFFFFFFFF, rd, er, lat, nwr);
         checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err%0d_resp got=%b/%h exp=1/0", i, er, rd); end
         checks++; if (lat !== 1 || nwr !== 0) begin failures++; $display("FAIL err%0d_timing got=%0d/%0d exp=1/0", i, lat, nwr); end
      end
   endtask

   task automatic test_reset_mid_merge();
      int w0;
      preload(8, 32'hCAFEF00D);
      @(negedge clk);
      w0 = wr_count;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h20; req_wdata = 32'h77;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;   // now in MERGE
      #1;
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rstm_we got=%b exp=0", mem_we); end
      @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (wr_count !== w0 || mem[8] !== 32'hCAFEF00D) begin failures++; $display("FAIL rstm_mem got=%0d/%h exp=%0d/cafef00d", wr_count, mem[8], w0); end
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL rstm_state got=%b/%b exp=1/0", req_ready, resp_valid); end
      @(posedge clk);
      #1;
      checks++; if (resp_valid !== 1'b0 || wr_count !== w0) begin failures++; $display("FAIL rstm_after got=%b/%0d exp=0/%0d", resp_valid, wr_count, w0); end
   endtask

   task automatic test_back_to_back();
      preload(5, 32'h01234567);
      preload(6, 32'h89ABCDEF);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h14;
      @(posedge clk);
      #1 req_addr = 32'h18;   // second request, req_valid held high
      checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_access got=%b/%b exp=0/0", req_ready, resp_valid); end
      @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'h01234567) begin failures++; $display("FAIL b2b_first got=%b/%b/%h exp=0/1/01234567", req_ready, resp_valid, resp_rdata); end
      @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b/%b exp=1/0", req_ready, resp_valid); end
      @(posedge clk);
      #1 req_valid = 1'b0;
      checks++; if (req_ready !== 1'b0 || mem_addr !== 32'h18) begin failures++; $display("FAIL b2b_accept2 got=%b/%h exp=0/00000018", req_ready, mem_addr); end
      @(posedge clk);
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h89ABCDEF) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/89abcdef", resp_valid, resp_rdata); end
      @(posedge clk);
   endtask

   task automatic test_random();
      logic [31:0] rd, erd; logic er, eer; int lat, elat, nwr, enwr;
      logic we; logic [1:0] sz; logic sg; logic [31:0] a, wd;
      for (int i = 0; i < 60; i++) begin
         we = 1'($urandom); sz = 2'($urandom_range(0, 3)); sg = 1'($urandom);
         a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(4 * MSZ, 4 * MSZ + 64))
                                         : 32'($urandom_range(0, 4 * MSZ - 1));
         wd = $urandom;
         model(we, sz, sg, a, wd, erd, eer, elat, enwr);
         do_req(we, sz, sg, a, wd, rd, er, lat, nwr);
         checks++;
         if (rd !== erd || er !== eer || lat !== elat || nwr !== enwr) begin
            failures++;
            $display("FAIL rand%0d we=%b sz=%0d a=%h got=%h/%b/%0d/%0d exp=%h/%b/%0d/%0d",
                     i, we, sz, a, rd, er, lat, nwr, erd, eer, elat, enwr);
         end
      end
      for (int k = 0; k < MSZ; k++) begin
         checks++;
         if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL rand_mem%0d got=%h exp=%h", k, mem[k], ref_mem[k]); end
      end
   endtask

   initial begin
      test_reset();
      for (int k = 0; k < MSZ; k++) preload(k, $urandom);
      test_word_store_load();
      test_byte_rmw();
      test_subword_loads();
      test_errors();
      test_reset_mid_merge();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
